// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
package imem_pkg;

   localparam int unsigned IW_DEF = 9;
   localparam int unsigned AW_DEF = 10;
   localparam logic [IW_DEF-1:0] HALT_DEF = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-style fetch queue: entry 0 is the registered head, empty slots hold zero.
module fetch_fifo #(
   parameter int unsigned W = 19,
   parameter int unsigned D = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic                     valid_o,
   output logic [$clog2(D+1)-1:0]   count_o
);

   localparam int unsigned CNTW = $clog2(D + 1);

   logic [W-1:0]    ent_all [D];
   logic [D-1:0]    vld_all;
   logic [CNTW-1:0] cnt_q, cnt_d, wr_idx;
   logic            do_pop, push_ok;

   // Write slot is computed after the pop has shifted the queue down.
   always_comb begin
      do_pop  = pop_i & vld_all[0];
      wr_idx  = cnt_q - CNTW'(do_pop);
      push_ok = push_i && (32'(wr_idx) < D);
      cnt_d   = cnt_q;
      if (flush_i) cnt_d = '0;
      else         cnt_d = wr_idx + CNTW'(push_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   for (genvar g = 0; g < D; g++) begin : g_ent
      logic [W-1:0] ent_q, ent_d, up_ent;
      logic         vld_q, vld_d, up_vld;

      if (g < D - 1) begin : g_mid
         assign up_ent = ent_all[g+1];
         assign up_vld = vld_all[g+1];
      end else begin : g_last
         assign up_ent = '0;
         assign up_vld = 1'b0;
      end

      always_comb begin
         ent_d = ent_q;
         vld_d = vld_q;
         if (flush_i) begin
            ent_d = '0;
            vld_d = 1'b0;
         end else begin
            if (do_pop) begin
               ent_d = up_ent;
               vld_d = up_vld;
            end
            if (push_ok && (wr_idx == CNTW'(g))) begin
               ent_d = din_i;
               vld_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ent_q <= '0;
            vld_q <= 1'b0;
         end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
         end
      end

      assign ent_all[g] = ent_q;
      assign vld_all[g] = vld_q;
   end

   assign dout_o  = ent_all[0];
   assign valid_o = vld_all[0];
   assign count_o = cnt_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with program-load port and credit-limited prefetch into a small queue.
module imem_fetch
   import imem_pkg::*;
#(
   parameter int unsigned   IW        = IW_DEF,
   parameter int unsigned   AW        = AW_DEF,
   parameter int unsigned   QD        = 2,
   parameter logic [IW-1:0] HALT_INST = '1
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          inst_ready,
   output logic          inst_valid,
   output logic [IW-1:0] inst,
   output logic [AW-1:0] inst_pc,
   output logic          halted,
   output logic          busy
);

   localparam int unsigned EW   = IW + AW;
   localparam int unsigned CNTW = $clog2(QD + 1);
   localparam int unsigned OCCW = $clog2(QD + 2);

   fetch_state_e    state_q, state_d;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d, rd_pc_q;
   logic [IW-1:0]   rd_data_q;
   logic            rd_vld_q, halted_q, halted_d, busy_q;
   logic [IW-1:0]   mem [2**AW];

   logic            redir, pop, fill, fill_halt, issue;
   logic [OCCW-1:0] occ;
   logic [EW-1:0]   head;
   logic            head_vld;
   logic [CNTW-1:0] q_cnt;

   // Next-state: a read is issued only if queue plus in-flight word stays within QD.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      redir      = redirect && (state_q != ST_IDLE);
      pop        = head_vld && inst_ready;
      fill       = rd_vld_q && !redir;
      fill_halt  = fill && (rd_data_q == HALT_INST);
      occ        = OCCW'(q_cnt) + OCCW'(rd_vld_q) - OCCW'(pop);
      issue      = (state_q == ST_RUN) && !redir && !fill_halt && (32'(occ) < QD);

      if (issue) fetch_pc_d = fetch_pc_q + AW'(1);
      if (pop && (head[IW-1:0] == HALT_INST)) halted_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               fetch_pc_d = start_pc;
               halted_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (fill_halt) state_d = ST_HALT;
         end
         default: ;
      endcase

      if (redir) begin
         state_d    = ST_RUN;
         fetch_pc_d = redirect_pc;
         halted_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= '0;
         halted_q   <= 1'b0;
         busy_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         busy_q     <= (state_d != ST_IDLE);
         rd_vld_q   <= issue;
         if (issue) rd_pc_q <= fetch_pc_q;
      end
   end

   // Storage is deliberately left out of reset so a loaded program survives it.
   always_ff @(posedge CLK) begin
      if ((state_q == ST_IDLE) && load_we) mem[load_addr] <= load_data;
      if (issue) rd_data_q <= mem[fetch_pc_q];
   end

   fetch_fifo #(
      .W (EW),
      .D (QD)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (reset_n),
      .flush_i (redir),
      .push_i  (fill),
      .pop_i   (pop),
      .din_i   ({rd_pc_q, rd_data_q}),
      .dout_o  (head),
      .valid_o (head_vld),
      .count_o (q_cnt)
   );

   assign inst_valid = head_vld;
   assign inst       = head[IW-1:0];
   assign inst_pc    = head[EW-1:IW];
   assign halted     = halted_q;
   assign busy       = busy_q;

endmodule
